// File: rtl/uart_cfg_ctrl.sv
// Configuration UART frame parser: assembles SYNC/ADDR/DATA/CHK frames and
// issues one valid/ready register write per frame that passes its checksum.
module uart_cfg_ctrl #(
    parameter int unsigned DATA_BYTES   = 2,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 100000
) (
    input  logic                      i_Clock,
    input  logic                      i_Rst_n,
    input  logic                      i_Rx_DV,
    input  logic [7:0]                i_Rx_Byte,
    output logic                      o_Wr_En,
    input  logic                      i_Wr_Ready,
    output logic [7:0]                o_Wr_Addr,
    output logic [8*DATA_BYTES-1:0]   o_Wr_Data,
    output logic                      o_Err_Chk,
    output logic                      o_Err_Timeout,
    output logic                      o_Err_Ovf,
    output logic                      o_Busy,
    output logic [15:0]               o_Wr_Count
);

    localparam int unsigned DATA_W = 8 * DATA_BYTES;
    localparam int unsigned BC_W   = $clog2(DATA_BYTES + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CLKS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_CHK   = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [7:0]        addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        chk_q, chk_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              err_chk_q, err_chk_d;
    logic              err_tmo_q, err_tmo_d;
    logic              err_ovf_q, err_ovf_d;
    logic              in_frame;
    logic              tmo_hit;

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        chk_d     = chk_q;
        bcnt_d    = bcnt_q;
        tmo_d     = TMO_W'(0);
        cnt_d     = cnt_q;
        err_chk_d = 1'b0;
        err_tmo_d = 1'b0;
        err_ovf_d = 1'b0;

        in_frame = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_CHK);
        tmo_hit  = in_frame && !i_Rx_DV && (tmo_q == TMO_W'(TIMEOUT_CLKS - 1));

        // Counter holds clocks elapsed since the last strobe; a byte always beats the terminal count
        if (in_frame) begin
            tmo_d = i_Rx_DV ? TMO_W'(1) : tmo_q + TMO_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                    state_d = S_ADDR;
                    tmo_d   = TMO_W'(1);
                end
            end
            S_ADDR: begin
                if (i_Rx_DV) begin
                    addr_d  = i_Rx_Byte;
                    chk_d   = i_Rx_Byte;
                    bcnt_d  = BC_W'(0);
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (i_Rx_DV) begin
                    data_d = (data_q << 8) | DATA_W'(i_Rx_Byte);
                    chk_d  = chk_q ^ i_Rx_Byte;
                    bcnt_d = bcnt_q + BC_W'(1);
                    if (bcnt_q == BC_W'(DATA_BYTES - 1)) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == chk_q) begin
                        state_d = S_WRITE;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                if (i_Rx_DV) begin
                    err_ovf_d = 1'b1;
                end
                if (wr_en_q && i_Wr_Ready) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (tmo_hit) begin
            err_tmo_d = 1'b1;
            state_d   = S_IDLE;
            tmo_d     = TMO_W'(0);
        end

        wr_en_d = (state_d == S_WRITE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= 8'd0;
            data_q    <= '0;
            chk_q     <= 8'd0;
            bcnt_q    <= '0;
            tmo_q     <= '0;
            cnt_q     <= 16'd0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_chk_q <= 1'b0;
            err_tmo_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            chk_q     <= chk_d;
            bcnt_q    <= bcnt_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            err_chk_q <= err_chk_d;
            err_tmo_q <= err_tmo_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    assign o_Wr_En       = wr_en_q;
    assign o_Wr_Addr     = addr_q;
    assign o_Wr_Data     = data_q;
    assign o_Err_Chk     = err_chk_q;
    assign o_Err_Timeout = err_tmo_q;
    assign o_Err_Ovf     = err_ovf_q;
    assign o_Busy        = busy_q;
    assign o_Wr_Count    = cnt_q;

endmodule

// File: doc/uart_cfg_ctrl.md
# uart_cfg_ctrl

Frame parser and write sequencer for the configuration UART path. Consumes the byte strobe from the UART receiver and assembles fixed-length command frames (sync, address, data, checksum). Each validated frame becomes one register-write transaction on a valid/ready port to the configuration register bank. Framing, checksum and inter-byte timeout errors are flagged with single-cycle pulses.

## Interface
Decided: one clock; reset is asynchronous and active-low.

Parameters:
- `DATA_BYTES`, default 2: data bytes per frame, sent MSB first; `DATA_W = 8*DATA_BYTES`; legal range 1..4.
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT_CLKS`, default 100000: maximum idle clocks between bytes inside a frame; must be ≥ 2.

Ports:
- `i_Clock`  in  1  system clock.
- `i_Rst_n`  in  1  asynchronous active-low reset.
- `i_Rx_DV`  in  1  one-cycle strobe: `i_Rx_Byte` is valid.
- `i_Rx_Byte`  in  8  received byte.
- `o_Wr_En`  out  1  write request (valid).
- `i_Wr_Ready`  in  1  register bank accepts the write.
- `o_Wr_Addr`  out  8  write address.
- `o_Wr_Data`  out  DATA_W  write data.
- `o_Err_Chk`  out  1  one-cycle pulse: checksum mismatch.
- `o_Err_Timeout`  out  1  one-cycle pulse: inter-byte timeout.
- `o_Err_Ovf`  out  1  one-cycle pulse: byte dropped while a write was pending.
- `o_Busy`  out  1  high in any state other than IDLE.
- `o_Wr_Count`  out  16  count of completed writes; wraps from 0xFFFF to 0.

## Operation
- Frame format: `SYNC_BYTE`, ADDR, D[DATA_BYTES-1]..D[0], CHK.
- CHK = XOR of ADDR and all data bytes. SYNC is excluded.
- States:
  - **IDLE**: a byte equal to `SYNC_BYTE` moves to ADDR. Any other byte is ignored silently; no error is raised.
  - **ADDR**: the next byte is latched as the address and seeds the running XOR. Moves to DATA.
  - **DATA**: shifts bytes into the data register, MSB first, and XORs each into the running checksum. After `DATA_BYTES` bytes, moves to CHK. The byte counter is `$clog2(DATA_BYTES+1)` bits wide.
  - **CHK**:
    - If the received byte equals the running XOR: move to WRITE and drive `o_Wr_En` high.
    - Otherwise: pulse `o_Err_Chk` and return to IDLE.
  - **WRITE**: hold `o_Wr_En`, `o_Wr_Addr` and `o_Wr_Data` stable until `o_Wr_En && i_Wr_Ready` is sampled high. On that cycle:
    - increment `o_Wr_Count`;
    - move to IDLE, with `o_Wr_En` low from the next cycle.
- A `SYNC_BYTE` value arriving in ADDR, DATA or CHK is treated as ordinary payload. The parser does not resynchronise mid-frame.
- Timeout:
  - Applies in ADDR, DATA and CHK only.
  - The counter clears on entry to each of these states and on every `i_Rx_DV`.
  - When the counter reaches `TIMEOUT_CLKS-1` with no byte: pulse `o_Err_Timeout`, go to IDLE and discard the partial frame.
  - If a byte and the terminal count occur on the same cycle, the byte wins and no timeout is raised.
- WRITE has no timeout. Any byte arriving in WRITE, including on the handshake cycle, is discarded and pulses `o_Err_Ovf`.
- Reset values (while `i_Rst_n` is low, and immediately after an assertion at any point mid-frame):
  - state IDLE;
  - all outputs 0, including `o_Wr_Count`, `o_Wr_Addr` and `o_Wr_Data`;
  - checksum and timeout counters cleared.

## Timing
- All outputs are registered.
- A byte strobe at cycle n changes state at n+1.
- A correct CHK byte at cycle n drives `o_Wr_En` = 1 at n+1, with address and data already stable.
- Handshake at cycle m: `o_Wr_En` = 0 and `o_Busy` = 0 at m+1; `o_Wr_Count` shows the new value at m+1.
- A new SYNC is accepted at m+1 at the earliest.
- With `i_Wr_Ready` held high, a write completes one cycle after `o_Wr_En` rises.
- Error pulses are asserted for exactly one cycle, at n+1 after the causing event.
- The timeout pulse occurs `TIMEOUT_CLKS` cycles after the last strobe: the counter reaches terminal count at cycle `TIMEOUT_CLKS-1` after the strobe, and the registered pulse follows one cycle later.
- `o_Wr_En` never deasserts without a handshake, except on reset.

## Test plan
All scenarios use `DATA_BYTES`=2, `SYNC_BYTE`=A5 and `TIMEOUT_CLKS`=50 unless stated.
- **Good frame**: send A5 10 12 34 36 with ready tied high -> one `o_Wr_En` pulse with addr 0x10 and data 0x1234; `o_Wr_Count`=1; no error pulses.
- **Bad checksum**: send A5 10 12 34 37 -> `o_Err_Chk` pulses once; no `o_Wr_En`; count unchanged. A following good frame A5 20 AB CD 46 writes 0x20 / 0xABCD.
- **Leading garbage**: send 00 FF 5A A5 20 AB CD 46 -> leading bytes ignored with no errors; a single write of 0x20 / 0xABCD.
- **Timeout**:
  - Send A5 10, then idle 60 cycles -> `o_Err_Timeout` pulses once, 50 cycles after the 10 strobe; `o_Busy` drops.
  - A subsequent full frame is accepted.
  - Bytes spaced exactly 48 clocks apart cause no timeout.
- **Backpressure**:
  - Hold `i_Wr_Ready` low for 10 cycles after `o_Wr_En` rises -> addr and data are stable throughout.
  - A byte sent during the wait pulses `o_Err_Ovf` and is dropped.
  - Write completes on ready; count increments by 1.
- **Reset mid-frame**: assert `i_Rst_n` low after A5 10 12 -> all outputs 0 asynchronously. After release, the frame A5 10 12 34 36 produces exactly one write with `o_Wr_Count`=1.
